// File: rtl/griffin_pkg.sv
// Shared BN254 field constants and the serial multiplier FSM state type.
package griffin_pkg;

   localparam int unsigned BN254_N_BITS = 254;
   localparam logic [BN254_N_BITS-1:0] BN254_P =
      254'h30644e72e131a029b85045b68181585d2833e84879b9709143e1f593f0000001;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } mul_state_e;

endpackage

// File: rtl/galois_add_three.sv
// Modular sum of three field elements, each < p: result = (num1+num2+num3) mod p.
// The raw sum is < 3p, so at most two subtractions of p are ever needed; both
// candidates are formed in parallel and the right one is selected.
module galois_add_three
   import griffin_pkg::*;
#(
   parameter int unsigned         N_BITS        = BN254_N_BITS,
   parameter logic [N_BITS-1:0]   PRIME_MODULUS = BN254_P
) (
   input  logic [N_BITS-1:0] num1,
   input  logic [N_BITS-1:0] num2,
   input  logic [N_BITS-1:0] num3,
   output logic [N_BITS-1:0] sum
);

   // Two guard bits hold any sum below 3p without overflow.
   localparam logic [N_BITS+1:0] P1 = {2'b00, PRIME_MODULUS};
   localparam logic [N_BITS+1:0] P2 = {1'b0, PRIME_MODULUS, 1'b0};

   logic [N_BITS+1:0] raw;
   logic [N_BITS+1:0] sub1;
   logic [N_BITS+1:0] sub2;

   // Select raw, raw-p or raw-2p, whichever lands in [0,p).
   always_comb begin
      raw  = {2'b00, num1} + {2'b00, num2} + {2'b00, num3};
      sub1 = raw - P1;
      sub2 = raw - P2;
      if (raw >= P2)
         sum = sub2[N_BITS-1:0];
      else if (raw >= P1)
         sum = sub1[N_BITS-1:0];
      else
         sum = raw[N_BITS-1:0];
   end

endmodule

// File: rtl/galois_mul_serial.sv
// Bit-serial modular multiplier: product = (num1*num2) mod p, MSB-first
// double-and-add, one multiplier bit per cycle, valid/ready on both sides.
module galois_mul_serial
   import griffin_pkg::*;
#(
   parameter int unsigned         N_BITS        = BN254_N_BITS,
   parameter logic [N_BITS-1:0]   PRIME_MODULUS = BN254_P
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [N_BITS-1:0] num1,
   input  logic [N_BITS-1:0] num2,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [N_BITS-1:0] product
);

   localparam int unsigned      CNT_W    = $clog2(N_BITS);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_BITS - 1);

   mul_state_e        state_q;
   logic [N_BITS-1:0] a_q;
   logic [N_BITS-1:0] b_q;
   logic [N_BITS-1:0] acc_q;
   logic [N_BITS-1:0] acc_d;
   logic [CNT_W-1:0]  cnt_q;
   logic              in_ready_q;
   logic              out_valid_q;
   logic [N_BITS-1:0] addend;

   // Multiplicand is added only when the current multiplier bit is set.
   always_comb begin
      addend = b_q[cnt_q] ? a_q : '0;
   end

   // acc_d = (2*acc + addend) mod p
   galois_add_three #(
      .N_BITS        (N_BITS),
      .PRIME_MODULUS (PRIME_MODULUS)
   ) u_step (
      .num1 (acc_q),
      .num2 (acc_q),
      .num3 (addend),
      .sum  (acc_d)
   );

   // Control FSM with registered handshake outputs; reset wins over everything.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         a_q         <= '0;
         b_q         <= '0;
         acc_q       <= '0;
         cnt_q       <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (in_valid && in_ready_q) begin
                  a_q        <= num1;
                  b_q        <= num2;
                  acc_q      <= '0;
                  cnt_q      <= CNT_LAST;
                  in_ready_q <= 1'b0;
                  state_q    <= ST_BUSY;
               end
            end
            ST_BUSY: begin
               acc_q <= acc_d;
               if (cnt_q == '0) begin
                  out_valid_q <= 1'b1;
                  state_q     <= ST_DONE;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            ST_DONE: begin
               // Accept frees the block; in_ready comes back one cycle later.
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state_q     <= ST_IDLE;
               end
            end
            default: begin
               out_valid_q <= 1'b0;
               in_ready_q  <= 1'b1;
               state_q     <= ST_IDLE;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign product   = acc_q;

endmodule

// File: tb/tb_galois_mul_serial.sv
// Directed and randomised checks for galois_mul_serial at the BN254 default size.
module tb_galois_mul_serial;

   localparam int NB = 254;
   localparam logic [NB-1:0] P =
      254'h30644e72e131a029b85045b68181585d2833e84879b9709143e1f593f0000001;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [NB-1:0] num1;
   logic [NB-1:0] num2;
   logic          out_valid;
   logic          out_ready;
   logic [NB-1:0] product;

   int n_total = 0;
   int n_pass  = 0;

   typedef struct {
      logic [NB-1:0] a;
      logic [NB-1:0] b;
      logic [NB-1:0] exp;
      int            stall;
      bit            pulse;
   } vec_t;

   vec_t vecs [7];

   galois_mul_serial dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .num1      (num1),
      .num2      (num2),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .product   (product)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [255:0] got, input logic [255:0] want);
      n_total++;
      if (got === want) n_pass++;
      else $display("FAIL %s: got %0h want %0h", name, got, want);
   endtask

   // Independent reference: full-width product then modulo.
   function automatic logic [NB-1:0] mulmod(input logic [NB-1:0] a, input logic [NB-1:0] b);
      logic [2*NB-1:0] w;
      logic [2*NB-1:0] r;
      w = {{NB{1'b0}}, a} * {{NB{1'b0}}, b};
      r = w % {{NB{1'b0}}, P};
      return r[NB-1:0];
   endfunction

   function automatic logic [NB-1:0] rand_fe();
      logic [255:0] x;
      logic [NB-1:0] t;
      for (int i = 0; i < 8; i++) x[i*32 +: 32] = $urandom;
      t = x[NB-1:0];
      return t % P;
   endfunction

   // One full transaction; inputs driven and outputs sampled on the falling edge.
   task automatic do_op(input logic [NB-1:0] a, input logic [NB-1:0] b,
                        input logic [NB-1:0] expv, input int stall, input bit pulse);
      int w;
      int lat;
      w = 0;
      while (!in_ready && w < 600) begin @(negedge clk); w++; end
      chk("in_ready_before_op", {255'b0, in_ready}, 256'd1);
      num1 = a; num2 = b; in_valid = 1'b1;
      @(negedge clk);
      // Operands must be sampled only at the handshake.
      in_valid = 1'b0; num1 = '0; num2 = '0;
      lat = 1;
      while (!out_valid && lat < 400) begin
         if (pulse && lat == 50) begin in_valid = 1'b1; num1 = NB'(3); num2 = NB'(3); end
         if (pulse && lat == 53) in_valid = 1'b0;
         @(negedge clk);
         lat++;
      end
      chk("latency_cycles", 256'(lat), 256'd255);
      chk("in_ready_in_done", {255'b0, in_ready}, 256'd0);
      for (int k = 0; k < stall; k++) begin
         chk("stall_product", {2'b0, product}, {2'b0, expv});
         chk("stall_out_valid", {255'b0, out_valid}, 256'd1);
         @(negedge clk);
      end
      chk("product", {2'b0, product}, {2'b0, expv});
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk("out_valid_after_accept", {255'b0, out_valid}, 256'd0);
      chk("in_ready_after_accept", {255'b0, in_ready}, 256'd1);
   endtask

   task automatic watch_quiet(input string name, input int cycles);
      int seen;
      seen = 0;
      for (int k = 0; k < cycles; k++) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      chk(name, 256'(seen), 256'd0);
   endtask

   initial begin
      // Hand-computed vectors.
      vecs[0] = '{a: NB'(2),  b: NB'(3),  exp: NB'(6),  stall: 0,  pulse: 1'b0};
      vecs[1] = '{a: P - 1,   b: P - 1,   exp: NB'(1),  stall: 0,  pulse: 1'b0};
      vecs[2] = '{a: P - 1,   b: NB'(2),  exp: P - 2,   stall: 0,  pulse: 1'b0};
      vecs[3] = '{a: NB'(0),  b: P - 1,   exp: NB'(0),  stall: 0,  pulse: 1'b0};
      vecs[4] = '{a: NB'(5),  b: NB'(0),  exp: NB'(0),  stall: 0,  pulse: 1'b0};
      vecs[5] = '{a: NB'(1),  b: P - 1,   exp: P - 1,   stall: 2,  pulse: 1'b0};
      vecs[6] = '{a: P - 1,   b: NB'(3),  exp: P - 3,   stall: 10, pulse: 1'b1};

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; num1 = '0; num2 = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk("reset_in_ready", {255'b0, in_ready}, 256'd1);
      chk("reset_out_valid", {255'b0, out_valid}, 256'd0);
      chk("reset_product", {2'b0, product}, 256'd0);

      // Table-driven directed operations, issued back to back.
      for (int i = 0; i < 7; i++)
         do_op(vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].stall, vecs[i].pulse);

      // The in_valid pulse during BUSY must not start a second operation.
      watch_quiet("no_extra_result", 300);
      chk("idle_after_pulse", {255'b0, in_ready}, 256'd1);

      // Abort mid-BUSY by reset; the partial result must never appear.
      num1 = NB'(11); num2 = NB'(13); in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (99) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_in_ready", {255'b0, in_ready}, 256'd1);
      chk("abort_out_valid", {255'b0, out_valid}, 256'd0);
      chk("abort_acc_cleared", {2'b0, product}, 256'd0);
      watch_quiet("abort_no_output", 300);
      do_op(NB'(7), NB'(9), NB'(63), 0, 1'b0);

      // Random operands with random output stalls.
      for (int i = 0; i < 30; i++) begin
         logic [NB-1:0] ra;
         logic [NB-1:0] rb;
         ra = rand_fe();
         rb = rand_fe();
         do_op(ra, rb, mulmod(ra, rb), int'($urandom_range(0, 4)), 1'b0);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
